// File: rtl/mem_bus_unit_pkg.sv
// Shared definitions for the memory bus unit: FSM state encoding and default widths.
package mem_bus_unit_pkg;

    localparam int unsigned DefAw = 16;
    localparam int unsigned DefDw = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_bus_unit_wait_counter.sv
// 4-bit loadable down-counter with zero flag; pacing for RAM wait cycles.
module mem_bus_unit_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_bus_unit.sv
// MAR/MDR stage turning controller strobes into timed synchronous-RAM accesses.
// Optional MEM_FAULT_EN adds an address range check against MEM_DEPTH.
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int unsigned AW          = DefAw,
    parameter int unsigned DW          = DefDw,
    parameter int unsigned WAIT_CYCLES = 1
`ifdef MEM_FAULT_EN
    ,
    parameter int unsigned MEM_DEPTH   = 65536
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lmar,
    input  logic          pcmar,
    input  logic          spmar,
    input  logic          lmdr,
    input  logic          mdrz,
    input  logic          mdrm,
    input  logic          mrw,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] sp,
    input  logic [DW-1:0] zbus,
    output logic [DW-1:0] mdr,
    output logic [AW-1:0] mar,
    output logic          busy,
    output logic          overrun,
    output logic          fault,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] mar_q, mar_n;
    logic [DW-1:0] mdr_q, mdr_d, mdr_n;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic          rd_q, rd_d;
    logic          overrun_q, overrun_d;
    logic          fault_q, fault_d;
    logic          start_wr, start_rd, range_bad;
    logic          cnt_load, cnt_dec, cnt_zero;

    mem_bus_unit_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign busy = (state_q != StIdle);

    always_comb begin
        mar_n = mar_q;
        if (lmar && !busy) begin
            if (pcmar) begin
                mar_n = pc;
            end else if (spmar) begin
                mar_n = sp;
            end else begin
                mar_n = zbus[AW-1:0];
            end
        end
    end

    assign mdr_n    = (lmdr && mdrz) ? zbus : mdr_q;
    assign start_wr = !busy && mrw;
    assign start_rd = !busy && lmdr && mdrm && !mrw;

`ifdef MEM_FAULT_EN
    assign range_bad = (32'(mar_n) >= MEM_DEPTH);
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mdr_d     = mdr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        en_d      = en_q;
        we_d      = we_q;
        rd_d      = rd_q;
        fault_d   = fault_q;
        overrun_d = overrun_q | (busy & (lmar | lmdr | mrw));
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_wr || start_rd) begin
                    if (range_bad) begin
                        // Out-of-range start: no RAM cycle, a read returns zero.
                        fault_d = 1'b1;
                        mdr_d   = start_rd ? '0 : mdr_n;
                    end else begin
                        state_d  = start_wr ? StWrite : StRead;
                        addr_d   = mar_n;
                        en_d     = 1'b1;
                        we_d     = start_wr;
                        rd_d     = start_rd;
                        cnt_load = 1'b1;
                        if (start_wr) begin
                            wdata_d = mdr_n;
                            mdr_d   = mdr_n;
                        end
                    end
                end else if (lmdr && mdrz) begin
                    mdr_d = zbus;
                end
            end
            StRead, StWrite: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = StDone;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                end
            end
            StDone: begin
                if (rd_q) begin
                    mdr_d = mem_rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mar_q     <= '0;
            mdr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            overrun_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_n;
            mdr_q     <= mdr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            en_q      <= en_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            overrun_q <= overrun_d;
            fault_q   <= fault_d;
        end
    end

    assign mar       = mar_q;
    assign mdr       = mdr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign overrun   = overrun_q;
`ifdef MEM_FAULT_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit with a synchronous RAM model (WAIT_CYCLES = 1).
module tb_mem_bus_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lmar, pcmar, spmar, lmdr, mdrz, mdrm, mrw;
    logic [15:0] pc, sp, zbus;
    logic [15:0] mdr, mar, mem_addr, mem_wdata, mem_rdata;
    logic        busy, overrun, fault, mem_en, mem_we;

    logic [15:0] ram [0:65535];
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    mem_bus_unit #(
        .AW          (16),
        .DW          (16),
        .WAIT_CYCLES (1)
`ifdef MEM_FAULT_EN
        ,
        .MEM_DEPTH   (256)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lmar      (lmar),
        .pcmar     (pcmar),
        .spmar     (spmar),
        .lmdr      (lmdr),
        .mdrz      (mdrz),
        .mdrm      (mdrm),
        .mrw       (mrw),
        .pc        (pc),
        .sp        (sp),
        .zbus      (zbus),
        .mdr       (mdr),
        .mar       (mar),
        .busy      (busy),
        .overrun   (overrun),
        .fault     (fault),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (reset) begin
            ram[16'h0040] <= 16'hC123;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        lmar = 0; pcmar = 0; spmar = 0; lmdr = 0; mdrz = 0; mdrm = 0; mrw = 0;
    endtask

    // Steps through an access, tallying busy/enable cycles; bounded at 20 cycles.
    task automatic run_access(output int busy_n, output int en_n, output int we_n,
                              output logic [15:0] a, output logic [15:0] d);
        busy_n = 0; en_n = 0; we_n = 0; a = 16'hxxxx; d = 16'hxxxx;
        while (busy && busy_n < 20) begin
            busy_n++;
            if (mem_en) en_n++;
            if (mem_we) begin
                we_n++;
                a = mem_addr;
                d = mem_wdata;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1; lmar = 1; pcmar = 1; lmdr = 1; mdrm = 1; mrw = 1;
        pc = 16'h1234; sp = 16'h5678; zbus = 16'h9ABC;
        tick(); tick();
        total++; if (mar !== 16'h0) $display("FAIL reset_mar got %h want 0000", mar); else passed++;
        total++; if (mdr !== 16'h0) $display("FAIL reset_mdr got %h want 0000", mdr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun);
        else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else passed++;
        total++; if (mem_en !== 1'b0) $display("FAIL reset_en got %b want 0", mem_en); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else passed++;
        total++; if (mem_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", mem_addr);
        else passed++;
        total++; if (mem_wdata !== 16'h0) $display("FAIL reset_wdata got %h want 0000", mem_wdata);
        else passed++;
        clear_strobes();
        reset = 0;
        tick();
    endtask

    task automatic test_read();
        int bn, en, wn;
        logic [15:0] a, d;
        pc = 16'h0040; lmar = 1; pcmar = 1;
        tick(); clear_strobes();
        total++; if (mar !== 16'h0040) $display("FAIL rd_mar got %h want 0040", mar); else passed++;
        lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        total++; if (mem_addr !== 16'h0040) $display("FAIL rd_addr got %h want 0040", mem_addr);
        else passed++;
        run_access(bn, en, wn, a, d);
        total++; if (bn != 3) $display("FAIL rd_busy_cycles got %0d want 3", bn); else passed++;
        total++; if (en != 2) $display("FAIL rd_en_cycles got %0d want 2", en); else passed++;
        total++; if (mdr !== 16'hC123) $display("FAIL rd_data got %h want c123", mdr); else passed++;
    endtask

    task automatic test_write();
        int bn, en, wn;
        logic [15:0] a, d;
        zbus = 16'hBEEF; lmdr = 1; mdrz = 1;
        tick(); clear_strobes();
        total++; if (mdr !== 16'hBEEF) $display("FAIL wr_zload got %h want beef", mdr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL wr_zload_busy got %b want 0", busy); else passed++;
        sp = 16'h00FF; lmar = 1; spmar = 1;
        tick(); clear_strobes();
        total++; if (mar !== 16'h00FF) $display("FAIL wr_mar got %h want 00ff", mar); else passed++;
        mrw = 1;
        tick(); clear_strobes();
        run_access(bn, en, wn, a, d);
        total++; if (wn != 2) $display("FAIL wr_we_cycles got %0d want 2", wn); else passed++;
        total++; if (a !== 16'h00FF) $display("FAIL wr_addr got %h want 00ff", a); else passed++;
        total++; if (d !== 16'hBEEF) $display("FAIL wr_data got %h want beef", d); else passed++;
        total++; if (ram[16'h00FF] !== 16'hBEEF)
            $display("FAIL wr_ram got %h want beef", ram[16'h00FF]); else passed++;
        zbus = 16'h0000; lmdr = 1; mdrz = 1;
        tick(); clear_strobes();
        lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        run_access(bn, en, wn, a, d);
        total++; if (mdr !== 16'hBEEF) $display("FAIL wr_readback got %h want beef", mdr);
        else passed++;
    endtask

    task automatic test_same_cycle();
        int bn, en, wn;
        logic [15:0] a, d;
        sp = 16'h0023; zbus = 16'h5A5A;
        lmar = 1; spmar = 1; mrw = 1; lmdr = 1; mdrz = 1;
        tick(); clear_strobes();
        total++; if (mar !== 16'h0023) $display("FAIL same_mar got %h want 0023", mar); else passed++;
        run_access(bn, en, wn, a, d);
        total++; if (a !== 16'h0023) $display("FAIL same_addr got %h want 0023", a); else passed++;
        total++; if (d !== 16'h5A5A) $display("FAIL same_data got %h want 5a5a", d); else passed++;
        total++; if (ram[16'h00FF] !== 16'hBEEF)
            $display("FAIL same_old_mar got %h want beef", ram[16'h00FF]); else passed++;
    endtask

    task automatic test_overrun();
        int bn, en, wn;
        logic [15:0] a, d;
        total++; if (overrun !== 1'b0) $display("FAIL ovr_initial got %b want 0", overrun);
        else passed++;
        pc = 16'h0040; lmar = 1; pcmar = 1; lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        pc = 16'h0099; lmar = 1; pcmar = 1; mrw = 1;
        tick(); clear_strobes();
        total++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else passed++;
        total++; if (mar !== 16'h0040) $display("FAIL ovr_mar got %h want 0040", mar); else passed++;
        run_access(bn, en, wn, a, d);
        total++; if (wn != 0) $display("FAIL ovr_no_write got %0d want 0", wn); else passed++;
        total++; if (mdr !== 16'hC123) $display("FAIL ovr_rd_data got %h want c123", mdr);
        else passed++;
        tick();
        total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun);
        else passed++;
    endtask

    task automatic test_reset_abort();
        lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_pre got %b want 1", busy); else passed++;
        reset = 1;
        tick();
        reset = 0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (mem_en !== 1'b0) $display("FAIL abort_en got %b want 0", mem_en); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL abort_overrun got %b want 0", overrun);
        else passed++;
        total++; if (mar !== 16'h0) $display("FAIL abort_mar got %h want 0000", mar); else passed++;
        tick();
    endtask

    task automatic test_fault();
`ifdef MEM_FAULT_EN
        int en_seen = 0;
        int busy_seen = 0;
        zbus = 16'h1111; lmdr = 1; mdrz = 1;
        tick(); clear_strobes();
        pc = 16'h0100; lmar = 1; pcmar = 1; lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        for (int i = 0; i < 5; i++) begin
            if (mem_en) en_seen++;
            if (busy) busy_seen++;
            tick();
        end
        total++; if (fault !== 1'b1) $display("FAIL fault_flag got %b want 1", fault); else passed++;
        total++; if (en_seen != 0) $display("FAIL fault_en got %0d want 0", en_seen); else passed++;
        total++; if (busy_seen != 0) $display("FAIL fault_busy got %0d want 0", busy_seen);
        else passed++;
        total++; if (mdr !== 16'h0) $display("FAIL fault_mdr got %h want 0000", mdr); else passed++;
`else
        pc = 16'hFFF0; lmar = 1; pcmar = 1; lmdr = 1; mdrm = 1;
        tick(); clear_strobes();
        total++; if (fault !== 1'b0) $display("FAIL fault_tied got %b want 0", fault); else passed++;
        total++; if (mem_en !== 1'b1) $display("FAIL nofault_en got %b want 1", mem_en); else passed++;
        for (int i = 0; i < 5; i++) tick();
`endif
    endtask

    initial begin
        clear_strobes();
        reset = 1; pc = 0; sp = 0; zbus = 0;
        test_reset();
        test_read();
        test_write();
        test_same_cycle();
        test_overrun();
        test_reset_abort();
        test_fault();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
